// File: rtl/framebuffer_reader.sv
// framebuffer_reader
//   Reads a scaled frame (IMG_WIDTH_OUT x IMG_HEIGHT_OUT) back out of the
//   output framebuffer RAM in raster order and streams it over a
//   valid/ready handshake with start-of-frame / end-of-line markers.
//   A small FIFO absorbs the 1-cycle RAM read latency, so backpressure
//   never drops or repeats a pixel.
//
// Ports
//   CLK, RESET_N        clock, async active-low reset
//   start               frame request (level, sampled only when idle)
//   IMG_WIDTH_OUT[10:0] frame width, latched on start
//   IMG_HEIGHT_OUT[9:0] frame height, latched on start
//   R_ADDR[16:0], rden  RAM read port; data returns on PIXEL_IN next cycle
//   PIXEL_IN[7:0]       RAM read data
//   PIXEL_OUT[7:0], sof, eol, pix_valid / pix_ready   output stream
//   busy                reading or draining a frame
//   done                frame complete, waiting for start to drop
module framebuffer_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        start,
    input  logic [10:0] IMG_WIDTH_OUT,
    input  logic [9:0]  IMG_HEIGHT_OUT,
    output logic [16:0] R_ADDR,
    output logic        rden,
    input  logic [7:0]  PIXEL_IN,
    output logic [7:0]  PIXEL_OUT,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        sof,
    output logic        eol,
    output logic        busy,
    output logic        done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } tag_t;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] pix;
    } entry_t;

    state_t        state, state_nxt;
    logic [10:0]   w_q;
    logic [20:0]   total;
    logic [16:0]   addr;
    logic [10:0]   x;
    logic [16:0]   last_addr;
    logic          inflight;
    tag_t          tag_q;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          issue_ok, last_issue, x_wrap, push, pop;

    // Count reads still in the RAM pipe as occupied slots, so the pixel
    // they return always has room when it lands.
    assign issue_ok   = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    assign last_issue = ({4'b0, addr} == total - 21'd1);
    assign x_wrap     = (x == w_q - 11'd1);

    assign push      = inflight;
    assign pix_valid = (count != '0);
    assign pop       = pix_valid && pix_ready;

    // Outputs are forced to zero when nothing is valid so they are
    // well defined every cycle, including straight out of reset.
    assign PIXEL_OUT = pix_valid ? mem[rd_ptr].pix : 8'd0;
    assign sof       = pix_valid ? mem[rd_ptr].sof : 1'b0;
    assign eol       = pix_valid ? mem[rd_ptr].eol : 1'b0;

    // Address is live while reading, otherwise shows the last issued one.
    assign R_ADDR = rden ? addr : last_addr;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rden      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (IMG_WIDTH_OUT == '0 || IMG_HEIGHT_OUT == '0)
                                ? S_DONE : S_READ;
            end
            S_READ: begin
                busy = 1'b1;
                rden = issue_ok;
                if (issue_ok && last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave as soon as this cycle's pop empties the FIFO, so
                // done lines up with the cycle after the final transfer.
                if (!inflight && (count == '0 || (count == CW'(1) && pop)))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read-side counters and the tag that travels with each read.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            w_q       <= '0;
            total     <= '0;
            addr      <= '0;
            x         <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
            tag_q     <= '0;
        end else begin
            inflight <= rden;
            if (rden) begin
                tag_q.sof <= (addr == '0);
                tag_q.eol <= x_wrap;
                last_addr <= addr;
                addr      <= addr + 17'd1;
                x         <= x_wrap ? 11'd0 : x + 11'd1;
            end
            if (state == S_IDLE && start) begin
                w_q   <= IMG_WIDTH_OUT;
                total <= 21'(IMG_WIDTH_OUT) * 21'(IMG_HEIGHT_OUT);
                addr  <= '0;
                x     <= '0;
            end
        end
    end

    // Storage needs no reset: nothing is visible until count is non-zero.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{sof: tag_q.sof, eol: tag_q.eol, pix: PIXEL_IN};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_reader.sv
module tb_framebuffer_reader;

    logic        CLK;
    logic        RESET_N;
    logic        start;
    logic [10:0] IMG_WIDTH_OUT;
    logic [9:0]  IMG_HEIGHT_OUT;
    logic [16:0] R_ADDR;
    logic        rden;
    logic [7:0]  PIXEL_IN;
    logic [7:0]  PIXEL_OUT;
    logic        pix_valid;
    logic        pix_ready;
    logic        sof;
    logic        eol;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    framebuffer_reader #(.FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start),
        .IMG_WIDTH_OUT(IMG_WIDTH_OUT), .IMG_HEIGHT_OUT(IMG_HEIGHT_OUT),
        .R_ADDR(R_ADDR), .rden(rden), .PIXEL_IN(PIXEL_IN),
        .PIXEL_OUT(PIXEL_OUT), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sof(sof), .eol(eol), .busy(busy), .done(done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM model: every location holds (addr + 10), one-cycle read latency.
    always_ff @(posedge CLK) begin
        if (rden) PIXEL_IN <= 8'(R_ADDR + 17'd10);
    end

    typedef struct packed {
        logic        rden;
        logic [16:0] raddr;
        logic        valid;
        logic [7:0]  pix;
        logic        sof;
        logic        eol;
        logic        busy;
        logic        done;
    } out_t;

    typedef struct packed {
        logic start;
        logic ready;
        out_t exp;
    } vec_t;

    function automatic vec_t mk(logic s, logic r, logic rd, int ra, logic v,
                                int px, logic so, logic eo, logic b, logic d);
        vec_t t;
        t.start = s;  t.ready = r;
        t.exp   = '{rden: rd, raddr: 17'(ra), valid: v, pix: 8'(px),
                    sof: so, eol: eo, busy: b, done: d};
        return t;
    endfunction

    function automatic out_t get_out();
        return '{rden: rden, raddr: R_ADDR, valid: pix_valid, pix: PIXEL_OUT,
                 sof: sof, eol: eol, busy: busy, done: done};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(int mode, int c);
        if (mode == 0) return 1'b1;
        return (c % 4 == 0) || (c % 4 == 3);   // 1,0,0,1 pattern
    endfunction

    // Drives one frame from its start cycle to done and checks it against
    // an independent model of issue rule, ordering, tags and completion.
    task automatic run_frame(input int w, input int h, input int mode,
                             input logic hold, input string tag);
        int total, issued, xfers, sofs, eols, last_addr, last_xfer_cyc, done_cyc;
        int bad_rden, bad_addr, bad_pix, bad_stable, bad_busy, bad_occ;
        logic pv, pr;
        logic [9:0] pbits;
        total = w * h;
        issued = 0; xfers = 0; sofs = 0; eols = 0;
        last_addr = -1; last_xfer_cyc = -1; done_cyc = -1;
        bad_rden = 0; bad_addr = 0; bad_pix = 0; bad_stable = 0; bad_busy = 0; bad_occ = 0;
        pv = 1'b0; pr = 1'b0; pbits = '0;
        @(negedge CLK);
        IMG_WIDTH_OUT = 11'(w); IMG_HEIGHT_OUT = 10'(h);
        start = 1'b1; pix_ready = rdy(mode, 0);
        for (int c = 1; c <= total * 4 + 40; c++) begin
            @(negedge CLK);
            start = hold; pix_ready = rdy(mode, c);
            #1;
            if (pv && !pr && !(pix_valid && {sof, eol, PIXEL_OUT} == pbits)) bad_stable++;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (!busy) bad_busy++;
            if (issued - xfers > 4) bad_occ++;
            if (rden !== ((issued < total) && (issued - xfers < 4))) bad_rden++;
            if (rden) begin
                if (int'(R_ADDR) != issued) bad_addr++;
                last_addr = int'(R_ADDR);
                issued++;
            end
            if (pix_valid && pix_ready) begin
                if (PIXEL_OUT !== 8'(xfers + 10) || sof !== (xfers == 0) ||
                    eol !== (xfers % w == w - 1)) bad_pix++;
                sofs += int'(sof);
                eols += int'(eol);
                xfers++;
                last_xfer_cyc = c;
            end
            pv = pix_valid; pr = pix_ready; pbits = {sof, eol, PIXEL_OUT};
        end
        check({tag, " done_reached"}, longint'(done_cyc > 0), 1);
        check({tag, " transfers"}, xfers, total);
        check({tag, " reads_issued"}, issued, total);
        check({tag, " last_raddr"}, last_addr, total - 1);
        check({tag, " sof_count"}, sofs, 1);
        check({tag, " eol_count"}, eols, h);
        check({tag, " rden_rule_errs"}, bad_rden, 0);
        check({tag, " raddr_errs"}, bad_addr, 0);
        check({tag, " pixel_errs"}, bad_pix, 0);
        check({tag, " stall_stable_errs"}, bad_stable, 0);
        check({tag, " busy_errs"}, bad_busy, 0);
        check({tag, " occupancy_errs"}, bad_occ, 0);
        check({tag, " done_cycle"}, done_cyc, last_xfer_cyc + 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        int   bad;

        // 4x2 frame, ready held high; cycle 0 is the start cycle.
        tbl[0]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 0,  0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 1, 1, 0,  0, 0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 1, 2, 1, 10, 1, 0, 1, 0);
        tbl[4]  = mk(0, 1, 1, 3, 1, 11, 0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 1, 4, 1, 12, 0, 0, 1, 0);
        tbl[6]  = mk(0, 1, 1, 5, 1, 13, 0, 1, 1, 0);
        tbl[7]  = mk(0, 1, 1, 6, 1, 14, 0, 0, 1, 0);
        tbl[8]  = mk(0, 1, 1, 7, 1, 15, 0, 0, 1, 0);
        tbl[9]  = mk(0, 1, 0, 7, 1, 16, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 0, 7, 1, 17, 0, 1, 1, 0);
        tbl[11] = mk(0, 1, 0, 7, 0,  0, 0, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 7, 0,  0, 0, 0, 0, 0);

        RESET_N = 1'b0; start = 1'b0; pix_ready = 1'b0;
        IMG_WIDTH_OUT = '0; IMG_HEIGHT_OUT = '0;
        repeat (3) @(negedge CLK);
        #1 check("reset_outputs", longint'(get_out()), 0);
        RESET_N = 1'b1;

        IMG_WIDTH_OUT = 11'd4; IMG_HEIGHT_OUT = 10'd2;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            start = tbl[i].start; pix_ready = tbl[i].ready;
            #1 check($sformatf("tbl_cycle%0d", i), longint'(get_out()), longint'(tbl[i].exp));
        end

        // Zero width: straight to done, never reads, never busy.
        @(negedge CLK);
        IMG_WIDTH_OUT = 11'd0; IMG_HEIGHT_OUT = 10'd2; start = 1'b1;
        #1 check("zero_w_c0", {rden, busy, done}, 3'b000);
        @(negedge CLK); start = 1'b0;
        #1 check("zero_w_c1", {rden, busy, done}, 3'b001);
        @(negedge CLK);
        #1 check("zero_w_c2", {rden, busy, done}, 3'b000);

        run_frame(4, 2, 1, 1'b0, "toggle");

        run_frame(320, 240, 0, 1'b1, "big");
        bad = 0;
        repeat (20) begin
            @(negedge CLK); start = 1'b1;
            #1 if (rden || busy || !done) bad++;
        end
        check("held_start_no_retrigger", bad, 0);
        @(negedge CLK); start = 1'b0;
        #1 check("drop_start_still_done", done, 1);
        @(negedge CLK); start = 1'b1;
        #1 check("rerun_c0_idle", {rden, busy, done}, 3'b000);
        @(negedge CLK); start = 1'b0;
        #1 check("rerun_c1_read", {rden, R_ADDR, busy}, {1'b1, 17'd0, 1'b1});
        @(negedge CLK);
        @(negedge CLK);
        #1 check("rerun_c3_sof", {pix_valid, sof, PIXEL_OUT}, {1'b1, 1'b1, 8'd10});

        // Abort the big rerun, then reset in the middle of a 4x2 frame.
        @(negedge CLK); RESET_N = 1'b0;
        @(negedge CLK); RESET_N = 1'b1;
        @(negedge CLK);
        IMG_WIDTH_OUT = 11'd4; IMG_HEIGHT_OUT = 10'd2; start = 1'b1; pix_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK); start = 1'b0;
        end
        #1 check("midframe_pixel5", {pix_valid, PIXEL_OUT}, {1'b1, 8'd15});
        #2 RESET_N = 1'b0;
        #1 check("async_reset_outputs", longint'(get_out()), 0);
        @(negedge CLK); RESET_N = 1'b1;
        run_frame(4, 2, 0, 1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Read-side counterpart of the scaling engine's framebuffer writer. Once a scaled frame of IMG_WIDTH_OUT x IMG_HEIGHT_OUT pixels has been written, this block reads the frame back from the output framebuffer RAM in raster order. It streams the pixels to the display/host path over a valid/ready handshake, with start-of-frame and end-of-line markers. A small internal FIFO absorbs the RAM read latency so backpressure never loses or duplicates a pixel.

## Interface
- FIFO_DEPTH, 4: pixel FIFO entries (power of two, ≥4); each entry is {sof, eol, pixel[7:0]}.
- CLK  in  1  single clock; all state updates on posedge.
- RESET_N  in  1  reset, asynchronous, active-low.
- start  in  1  frame request, level; sampled only in S_IDLE.
- IMG_WIDTH_OUT  in  11  frame width in pixels; latched on start.
- IMG_HEIGHT_OUT  in  10  frame height in lines; latched on start.
- R_ADDR  out  17  framebuffer read address (linear, y*W+x).
- rden  out  1  read strobe; RAM returns PIXEL_IN exactly 1 cycle later.
- PIXEL_IN  in  8  framebuffer read data.
- PIXEL_OUT  out  8  streamed pixel (FIFO head).
- pix_valid  out  1  PIXEL_OUT/sof/eol valid.
- pix_ready  in  1  sink accepts; a transfer occurs when pix_valid && pix_ready.
- sof  out  1  head pixel is (0,0).
- eol  out  1  head pixel is last of its line.
- busy  out  1  high in S_READ and S_DRAIN.
- done  out  1  high in S_DONE.

## Operation
- States: S_IDLE, S_READ, S_DRAIN, S_DONE.
- S_IDLE: on start=1, latch W, H and total = W*H (21-bit product), clear x, y, addr, and go to S_READ. If W==0 or H==0, go to S_DONE directly; no rden is issued.
- S_READ: issue rden=1 with R_ADDR=addr when (fifo_count + inflight) < FIFO_DEPTH. inflight is the registered previous rden.
  - On each issue: addr+1; x+1, wrapping to 0 with y+1 when x==W-1.
  - The tag stored with the pixel is sof=(addr==0) and eol=(x==W-1), captured at issue and delayed alongside inflight.
  - After the issue of addr==total-1, go to S_DRAIN.
- S_DRAIN: no reads. Go to S_DONE when fifo_count==0 and inflight==0.
- S_DONE: done=1. Go to S_IDLE when start==0, so a held start never retriggers.
- FIFO push: when inflight==1, write {tag, PIXEL_IN}. FIFO pop: on transfer. Simultaneous push and pop leaves count unchanged. A push never targets a full FIFO; the issue rule guarantees this.
- R_ADDR is the low 17 bits of addr. The caller guarantees W*H ≤ 131072.
- R_ADDR holds its last value when rden=0. Outputs are defined every cycle.

## Timing
- Reset (RESET_N=0, asynchronous) values:
  - state=S_IDLE.
  - rden=0, R_ADDR=0, PIXEL_OUT=0, pix_valid=0, sof=0, eol=0, busy=0, done=0.
  - FIFO empty, inflight=0, counters 0.
- Reset asserted mid-frame clears the block immediately. Pending RAM data is ignored. After release the block waits in S_IDLE for start.
- Latency, with cycle 0 as the cycle in which start=1 is seen in S_IDLE:
  - cycle 1: rden=1, R_ADDR=0.
  - cycle 2: PIXEL_IN valid, pushed at the end of the cycle.
  - cycle 3: pix_valid=1, sof=1.
- Throughput is 1 pixel/cycle with pix_ready held high.
- PIXEL_OUT, sof and eol are stable while pix_valid=1 and pix_ready=0.
- done asserts the cycle after the last pixel's transfer empties the FIFO.
- busy and done are never high together.

## Test plan
- 4x2 frame, ready=1, RAM holds addr+10:
  - rden on cycles 1–8 with R_ADDR 0..7.
  - PIXEL_OUT 10..17 on cycles 3–10.
  - sof on 10 only; eol on 13 and 17.
  - done=1 on cycle 11.
- Same frame, pix_ready toggled 1,0,0,1,…:
  - every pixel delivered once, in order.
  - fifo_count never exceeds 4.
  - rden stalls whenever count+inflight==4.
- IMG_WIDTH_OUT=0, start=1: no rden; done=1 on cycle 1; busy stays 0.
- 320x240 frame, ready=1:
  - 76800 transfers; last R_ADDR=76799.
  - eol count 240; sof count 1.
  - start held high after done gives no second frame; drop start, re-raise, and the frame repeats.
- RESET_N pulsed low at pixel 5 of a 4x2 frame:
  - all outputs 0 asynchronously.
  - a new start after release streams a full clean frame starting with sof.
